// File: rtl/row_policy_translator.sv
// row_policy_translator
//   Turns one host command (read/write, row, col, bank, auto_precharge) into
//   its DRAM sequence of PRECHARGE / ACTIVE / READ|WRITE issue entries, keeping
//   an open-row table per bank (open-page policy) and serialising refresh.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready/cmd_in    upstream host command handshake
//   issue_valid/issue_ready/issue_cmd  downstream issue FIFO handshake
//   refresh_req/refresh_ack       refresh request level / 1-cycle hand-off pulse
//   bank_open                     open-row valid bit per bank
// Optional: define XLATE_STATS_EN to add hit_cnt/miss_cnt/conflict_cnt.
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif

package row_policy_pkg;
    localparam int BA_W  = `BA_BITS;
    localparam int ROW_W = `ROW_BITS;
    localparam int COL_W = `COL_BITS;
    localparam logic R_W_READ  = 1'b1;
    localparam logic R_W_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ATCMD_NOP       = 3'd0,
        ATCMD_PRECHARGE = 3'd1,
        ATCMD_ACTIVE    = 3'd2,
        ATCMD_READ      = 3'd3,
        ATCMD_WRITE     = 3'd4,
        ATCMD_REFRESH   = 3'd5
    } atcmd_t;

    typedef struct packed {
        logic             r_w;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [BA_W-1:0]  bank;
        logic             auto_precharge;
    } command_t;

    typedef struct packed {
        atcmd_t                 command;
        logic [ROW_W+COL_W-1:0] addr;
        logic [BA_W-1:0]        bank;
    } issue_fifo_cmd_in_t;
endpackage

module row_policy_translator
    import row_policy_pkg::*;
#(
    parameter int NUM_BANKS = (1 << `BA_BITS)
`ifdef XLATE_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [$bits(command_t)-1:0]           cmd_in,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [$bits(issue_fifo_cmd_in_t)-1:0] issue_cmd,
    input  logic                                  refresh_req,
    output logic                                  refresh_ack,
`ifdef XLATE_STATS_EN
    output logic [CNT_W-1:0]                      hit_cnt,
    output logic [CNT_W-1:0]                      miss_cnt,
    output logic [CNT_W-1:0]                      conflict_cnt,
`endif
    output logic [NUM_BANKS-1:0]                  bank_open
);

    typedef enum logic [2:0] {
        X_IDLE, X_DECODE, X_PRE, X_ACT, X_RW, X_REF_PRE, X_REF
    } state_t;

    localparam logic [BA_W-1:0] LAST_IDX = BA_W'(NUM_BANKS - 1);

    state_t             state_r, state_s;
    command_t           cmd_r, cmd_in_s;
    logic [ROW_W-1:0]   open_row_r [NUM_BANKS];
    logic [BA_W-1:0]    idx_r, idx_s;
    logic               ap_pre_r, ap_pre_s;
    logic               issue_valid_s, refresh_ack_s;
    issue_fifo_cmd_in_t issue_cmd_r, issue_cmd_s;
    logic               open_set_s, open_clr_s;
    logic [BA_W-1:0]    open_bank_s;
    logic               accept_s, xfer_s, hit_s, miss_s, conflict_s;

    function automatic issue_fifo_cmd_in_t mk_issue(input atcmd_t c, input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col, input logic [BA_W-1:0] bank);
        issue_fifo_cmd_in_t e;
        e.command = c;
        e.addr    = {row, col};
        e.bank    = bank;
        return e;
    endfunction

    assign cmd_in_s    = command_t'(cmd_in);
    assign issue_cmd   = issue_cmd_r;
    // Refresh outranks new commands; reset also forces not-ready.
    assign cmd_ready   = (state_r == X_IDLE) & ~refresh_req & ~rst;
    assign accept_s    = cmd_valid & cmd_ready;
    assign xfer_s      = issue_valid & issue_ready;

    // Next-state, next issue entry and open-row table update requests.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        ap_pre_s      = ap_pre_r;
        issue_valid_s = issue_valid;
        issue_cmd_s   = issue_cmd_r;
        refresh_ack_s = 1'b0;
        open_set_s    = 1'b0;
        open_clr_s    = 1'b0;
        open_bank_s   = cmd_r.bank;
        hit_s         = 1'b0;
        miss_s        = 1'b0;
        conflict_s    = 1'b0;
        case (state_r)
            X_IDLE: begin
                if (refresh_req) begin
                    state_s = X_REF_PRE;
                    idx_s   = {BA_W{1'b0}};
                end else if (accept_s) begin
                    state_s = X_DECODE;
                end else begin
                    state_s = X_IDLE;
                end
            end
            X_DECODE: begin
                issue_valid_s = 1'b1;
                if (bank_open[cmd_r.bank] && (open_row_r[cmd_r.bank] == cmd_r.row)) begin
                    hit_s       = 1'b1;
                    state_s     = X_RW;
                    issue_cmd_s = mk_issue((cmd_r.r_w == R_W_READ) ? ATCMD_READ : ATCMD_WRITE,
                                           cmd_r.row, cmd_r.col, cmd_r.bank);
                end else if (bank_open[cmd_r.bank]) begin
                    conflict_s  = 1'b1;
                    state_s     = X_PRE;
                    ap_pre_s    = 1'b0;
                    issue_cmd_s = mk_issue(ATCMD_PRECHARGE, open_row_r[cmd_r.bank],
                                           {COL_W{1'b0}}, cmd_r.bank);
                end else begin
                    miss_s      = 1'b1;
                    state_s     = X_ACT;
                    issue_cmd_s = mk_issue(ATCMD_ACTIVE, cmd_r.row, {COL_W{1'b0}}, cmd_r.bank);
                end
            end
            X_PRE: begin
                if (xfer_s) begin
                    open_clr_s = 1'b1;
                    // A precharge that closes an auto-precharge access ends the command.
                    if (ap_pre_r) begin
                        state_s       = X_IDLE;
                        ap_pre_s      = 1'b0;
                        issue_valid_s = 1'b0;
                        issue_cmd_s   = mk_issue(ATCMD_NOP, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                    end else begin
                        state_s     = X_ACT;
                        issue_cmd_s = mk_issue(ATCMD_ACTIVE, cmd_r.row, {COL_W{1'b0}}, cmd_r.bank);
                    end
                end else begin
                    state_s = X_PRE;
                end
            end
            X_ACT: begin
                if (xfer_s) begin
                    open_set_s  = 1'b1;
                    state_s     = X_RW;
                    issue_cmd_s = mk_issue((cmd_r.r_w == R_W_READ) ? ATCMD_READ : ATCMD_WRITE,
                                           cmd_r.row, cmd_r.col, cmd_r.bank);
                end else begin
                    state_s = X_ACT;
                end
            end
            X_RW: begin
                if (xfer_s && cmd_r.auto_precharge) begin
                    state_s     = X_PRE;
                    ap_pre_s    = 1'b1;
                    issue_cmd_s = mk_issue(ATCMD_PRECHARGE, cmd_r.row, {COL_W{1'b0}}, cmd_r.bank);
                end else if (xfer_s) begin
                    state_s       = X_IDLE;
                    issue_valid_s = 1'b0;
                    issue_cmd_s   = mk_issue(ATCMD_NOP, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                end else begin
                    state_s = X_RW;
                end
            end
            X_REF_PRE: begin
                // Each bank is examined with no entry pending; an open bank then
                // gets a PRECHARGE loaded and the walk waits for its transfer.
                open_bank_s = idx_r;
                if (issue_valid) begin
                    if (issue_ready) begin
                        open_clr_s = 1'b1;
                        if (idx_r == LAST_IDX) begin
                            state_s     = X_REF;
                            issue_cmd_s = mk_issue(ATCMD_REFRESH, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                        end else begin
                            idx_s         = idx_r + 1'b1;
                            issue_valid_s = 1'b0;
                            issue_cmd_s   = mk_issue(ATCMD_NOP, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                        end
                    end else begin
                        state_s = X_REF_PRE;
                    end
                end else if (bank_open[idx_r]) begin
                    issue_valid_s = 1'b1;
                    issue_cmd_s   = mk_issue(ATCMD_PRECHARGE, open_row_r[idx_r], {COL_W{1'b0}}, idx_r);
                end else if (idx_r == LAST_IDX) begin
                    state_s       = X_REF;
                    issue_valid_s = 1'b1;
                    issue_cmd_s   = mk_issue(ATCMD_REFRESH, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                end else begin
                    idx_s = idx_r + 1'b1;
                end
            end
            X_REF: begin
                if (xfer_s) begin
                    refresh_ack_s = 1'b1;
                    state_s       = X_IDLE;
                    issue_valid_s = 1'b0;
                    issue_cmd_s   = mk_issue(ATCMD_NOP, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
                end else begin
                    state_s = X_REF;
                end
            end
            default: begin
                state_s       = X_IDLE;
                issue_valid_s = 1'b0;
                issue_cmd_s   = mk_issue(ATCMD_NOP, {ROW_W{1'b0}}, {COL_W{1'b0}}, {BA_W{1'b0}});
            end
        endcase
    end

    // State, latched command, registered issue outputs and open-row table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= X_IDLE;
            cmd_r       <= '0;
            idx_r       <= {BA_W{1'b0}};
            ap_pre_r    <= 1'b0;
            issue_valid <= 1'b0;
            issue_cmd_r <= '0;
            refresh_ack <= 1'b0;
            bank_open   <= {NUM_BANKS{1'b0}};
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row_r[i] <= {ROW_W{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            ap_pre_r    <= ap_pre_s;
            issue_valid <= issue_valid_s;
            issue_cmd_r <= issue_cmd_s;
            refresh_ack <= refresh_ack_s;
            if (accept_s) begin
                cmd_r <= cmd_in_s;
            end
            if (open_clr_s) begin
                bank_open[open_bank_s] <= 1'b0;
            end else if (open_set_s) begin
                bank_open[open_bank_s]  <= 1'b1;
                open_row_r[open_bank_s] <= cmd_r.row;
            end
        end
    end

`ifdef XLATE_STATS_EN
    // Saturating decode-outcome counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt      <= {CNT_W{1'b0}};
            miss_cnt     <= {CNT_W{1'b0}};
            conflict_cnt <= {CNT_W{1'b0}};
        end else begin
            if (hit_s && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + 1'b1;
            if (miss_s && (miss_cnt != {CNT_W{1'b1}})) miss_cnt <= miss_cnt + 1'b1;
            if (conflict_s && (conflict_cnt != {CNT_W{1'b1}})) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule
